axi_rcache: RTL and testbench

AXI_RCACHE -- requirements
Module: axi_rcache

---
 rtl/axi_rcache_if.sv | 40 ++++
 rtl/axi_rcache.sv | 216 +++++++++++++++++++++
 tb/tb_axi_rcache.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rcache_if.sv
// AXI read-channel bundle for axi_rcache: CPU-facing s_* channels and memory-facing m_* channels.
// The slave modport is the cache's view; the master modport is the surrounding system's view.
interface axi_rcache_if #(
  parameter int ID_W = 6
);
  logic            s_ar_valid;
  logic            s_ar_ready;
  logic [ID_W-1:0] s_ar_id;
  logic [31:0]     s_ar_addr;
  logic [7:0]      s_ar_len;
  logic            s_r_valid;
  logic            s_r_ready;
  logic [ID_W-1:0] s_r_id;
  logic [63:0]     s_r_data;
  logic [1:0]      s_r_resp;
  logic            s_r_last;
  logic            m_ar_valid;
  logic            m_ar_ready;
  logic [31:0]     m_ar_addr;
  logic [7:0]      m_ar_len;
  logic            m_r_valid;
  logic            m_r_ready;
  logic [63:0]     m_r_data;
  logic [1:0]      m_r_resp;
  logic            m_r_last;

  modport slave (
    input  s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_r_ready,
           m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    output s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
           m_ar_valid, m_ar_addr, m_ar_len, m_r_ready
  );

  modport master (
    output s_ar_valid, s_ar_id, s_ar_addr, s_ar_len, s_r_ready,
           m_ar_ready, m_r_valid, m_r_data, m_r_resp, m_r_last,
    input  s_ar_ready, s_r_valid, s_r_id, s_r_data, s_r_resp, s_r_last,
           m_ar_valid, m_ar_addr, m_ar_len, m_r_ready
  );
endinterface

// File: rtl/axi_rcache.sv
// Set-associative AXI read cache: single-beat reads are cached, bursts bypass to memory.
// Define RCACHE_INV_EN to add the inv_valid/inv_addr write-snoop invalidate port.
module axi_rcache #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_BEATS = 2,
  parameter int ID_W       = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  axi_rcache_if.slave bus
`ifdef RCACHE_INV_EN
  ,
  input  logic        inv_valid,
  input  logic [31:0] inv_addr
`endif
);
  localparam int BEAT_B  = $clog2(LINE_BEATS);
  localparam int BEAT_W  = (BEAT_B > 0) ? BEAT_B : 1;
  localparam int SET_W   = $clog2(SETS);
  localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_LSB = 3 + BEAT_B + SET_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [2:0] {IDLE, LOOKUP, RESP, FILL_REQ, FILL, BYP_REQ, BYP} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic [63:0]      rdata_q;
  logic [1:0]       resp_q, err_q;
  logic [WAY_W-1:0] victim_q;
  logic [BEAT_W-1:0] beatCnt_q;
  logic             invHit_q;
  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAY_W-1:0] rr_q [SETS];
  logic [TAG_W-1:0] tagMem [SETS][WAYS];
  logic [63:0]      dataMem [SETS][WAYS][LINE_BEATS];

  function automatic logic [SET_W-1:0] setOf(input logic [31:0] a);
    setOf = a[3+BEAT_B +: SET_W];
  endfunction

  function automatic logic [TAG_W-1:0] tagOf(input logic [31:0] a);
    tagOf = a[TAG_LSB +: TAG_W];
  endfunction

  function automatic logic [BEAT_W-1:0] beatOf(input logic [31:0] a);
    beatOf = (LINE_BEATS > 1) ? a[3 +: BEAT_W] : '0;
  endfunction

  logic [SET_W-1:0]  reqSet;
  logic [TAG_W-1:0]  reqTag;
  logic [BEAT_W-1:0] reqBeat;
  assign reqSet  = setOf(addr_q);
  assign reqTag  = tagOf(addr_q);
  assign reqBeat = beatOf(addr_q);

  // Hit search and victim choice: first invalid way wins, otherwise the set's round-robin pointer.
  logic             hit, foundInvalid;
  logic [WAY_W-1:0] hitWay, victim;
  always_comb begin
    hit          = 1'b0;
    hitWay       = '0;
    foundInvalid = 1'b0;
    victim       = rr_q[reqSet];
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[reqSet][w] && (tagMem[reqSet][w] == reqTag) && !hit) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
      if (!valid_q[reqSet][w] && !foundInvalid) begin
        foundInvalid = 1'b1;
        victim       = WAY_W'(w);
      end
    end
  end

  logic       beatFire, fillDone;
  logic [1:0] fillResp;
  assign beatFire = (state_q == FILL) && bus.m_r_valid;
  assign fillDone = beatFire && bus.m_r_last;
  assign fillResp = (err_q != 2'b00) ? err_q : bus.m_r_resp;

  logic [WAYS-1:0]  invMask;
  logic [SET_W-1:0] invSet;
  logic             invFill;
`ifdef RCACHE_INV_EN
  assign invSet  = setOf(inv_addr);
  assign invFill = inv_valid && ((state_q == FILL_REQ) || (state_q == FILL)) &&
                   (invSet == reqSet) && (tagOf(inv_addr) == reqTag);
  always_comb begin
    invMask = '0;
    for (int w = 0; w < WAYS; w++) begin
      invMask[w] = inv_valid && valid_q[invSet][w] && (tagMem[invSet][w] == tagOf(inv_addr));
    end
  end
`else
  assign invSet  = '0;
  assign invFill = 1'b0;
  assign invMask = '0;
`endif

  always_comb begin
    state_d        = state_q;
    bus.s_ar_ready = (state_q == IDLE);
    bus.s_r_valid  = 1'b0;
    bus.s_r_id     = '0;
    bus.s_r_data   = '0;
    bus.s_r_resp   = 2'b00;
    bus.s_r_last   = 1'b0;
    bus.m_ar_valid = 1'b0;
    bus.m_ar_addr  = '0;
    bus.m_ar_len   = '0;
    bus.m_r_ready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.s_ar_valid) state_d = (bus.s_ar_len == 8'd0) ? LOOKUP : BYP_REQ;
      end
      LOOKUP: state_d = hit ? RESP : FILL_REQ;
      RESP: begin
        bus.s_r_valid = 1'b1;
        bus.s_r_id    = id_q;
        bus.s_r_data  = rdata_q;
        bus.s_r_resp  = resp_q;
        bus.s_r_last  = 1'b1;
        if (bus.s_r_ready) state_d = IDLE;
      end
      FILL_REQ: begin
        bus.m_ar_valid = 1'b1;
        bus.m_ar_addr  = addr_q & ~32'(LINE_BEATS * 8 - 1);
        bus.m_ar_len   = 8'(LINE_BEATS - 1);
        if (bus.m_ar_ready) state_d = FILL;
      end
      FILL: begin
        bus.m_r_ready = 1'b1;
        if (fillDone) state_d = RESP;
      end
      BYP_REQ: begin
        bus.m_ar_valid = 1'b1;
        bus.m_ar_addr  = addr_q;
        bus.m_ar_len   = len_q;
        if (bus.m_ar_ready) state_d = BYP;
      end
      BYP: begin
        bus.s_r_valid = bus.m_r_valid;
        bus.s_r_id    = id_q;
        bus.s_r_data  = bus.m_r_data;
        bus.s_r_resp  = bus.m_r_resp;
        bus.s_r_last  = bus.m_r_last;
        bus.m_r_ready = bus.s_r_ready;
        if (bus.m_r_valid && bus.s_r_ready && bus.m_r_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The victim's valid bit drops as soon as a miss is decided, so a stale line never outlives its refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      err_q     <= 2'b00;
      victim_q  <= '0;
      beatCnt_q <= '0;
      invHit_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && bus.s_ar_valid) begin
        id_q   <= bus.s_ar_id;
        addr_q <= bus.s_ar_addr;
        len_q  <= bus.s_ar_len;
      end
      if (state_q == LOOKUP) begin
        if (hit) begin
          rdata_q <= dataMem[reqSet][hitWay][reqBeat];
          resp_q  <= 2'b00;
        end else begin
          victim_q                <= victim;
          valid_q[reqSet][victim] <= 1'b0;
          beatCnt_q               <= '0;
          err_q                   <= 2'b00;
          invHit_q                <= 1'b0;
        end
      end
      if (invFill) invHit_q <= 1'b1;
      if (beatFire) begin
        beatCnt_q <= beatCnt_q + BEAT_W'(1);
        if (beatCnt_q == reqBeat) rdata_q <= bus.m_r_data;
        if ((err_q == 2'b00) && (bus.m_r_resp != 2'b00)) err_q <= bus.m_r_resp;
      end
      if (fillDone) begin
        resp_q       <= fillResp;
        rr_q[reqSet] <= (WAYS > 1) ? rr_q[reqSet] + WAY_W'(1) : '0;
        if ((fillResp == 2'b00) && !invHit_q && !invFill) valid_q[reqSet][victim_q] <= 1'b1;
      end
      for (int w = 0; w < WAYS; w++) begin
        if (invMask[w]) valid_q[invSet][w] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == LOOKUP) && !hit) tagMem[reqSet][victim] <= reqTag;
    if (beatFire) dataMem[reqSet][victim_q][beatCnt_q] <= bus.m_r_data;
  end
endmodule

// File: tb/tb_axi_rcache.sv
// Directed self-checking bench for axi_rcache (WAYS=4, SETS=256, LINE_BEATS=2); memory is a behavioural responder.
// With RCACHE_INV_EN defined the snoop-invalidate scenario is also exercised.
module tb_axi_rcache;
  localparam int ID_W = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_rcache_if #(.ID_W(ID_W)) bus ();
`ifdef RCACHE_INV_EN
  logic        inv_valid = 1'b0;
  logic [31:0] inv_addr  = '0;
`endif

  axi_rcache #(.WAYS(4), .SETS(256), .LINE_BEATS(2), .ID_W(ID_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef RCACHE_INV_EN
    ,
    .inv_valid (inv_valid),
    .inv_addr  (inv_addr)
`endif
  );

  int checksTotal = 0;
  int checksPassed = 0;
  int cyc = 0;
  int arCount = 0;
  logic [31:0] lastArAddr = '0;
  logic [7:0]  lastArLen = '0;
  int errBeat = -1;
  logic [1:0] errCode = 2'b00;
  logic [31:0] memAddr;
  int memLen;
  int waitMem;

  logic [63:0] rxData [16];
  logic [1:0]  rxResp [16];
  logic        rxLast [16];
  logic [ID_W-1:0] rxId;
  int rxCount, latency, arDelta;
  logic rxDone, stableOk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] memWord(input logic [31:0] a);
    memWord = {a, a ^ 32'hA5A5_5A5A};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Memory responder: accepts every AR and returns len+1 beats of address-derived data.
  initial begin
    bus.m_ar_ready = 1'b1;
    bus.m_r_valid  = 1'b0;
    bus.m_r_data   = '0;
    bus.m_r_resp   = 2'b00;
    bus.m_r_last   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.m_ar_valid) begin
        memAddr    = bus.m_ar_addr;
        memLen     = int'(bus.m_ar_len);
        lastArAddr = bus.m_ar_addr;
        lastArLen  = bus.m_ar_len;
        arCount++;
        @(posedge clk); #1;
        for (int i = 0; i <= memLen; i++) begin
          bus.m_r_valid = 1'b1;
          bus.m_r_data  = memWord(memAddr + 32'(i * 8));
          bus.m_r_resp  = (i == errBeat) ? errCode : 2'b00;
          bus.m_r_last  = (i == memLen);
          waitMem = 0;
          @(negedge clk);
          while (!bus.m_r_ready && waitMem < 100) begin
            @(negedge clk);
            waitMem++;
          end
          @(posedge clk); #1;
        end
        bus.m_r_valid = 1'b0;
        bus.m_r_last  = 1'b0;
        bus.m_r_resp  = 2'b00;
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [7:0] len,
                               input logic [ID_W-1:0] id, input int stall);
    int hsCyc, arBefore, guard, stallLeft;
    logic [63:0] held;
    logic seen;
    arBefore  = arCount;
    rxCount   = 0;
    rxDone    = 1'b0;
    stableOk  = 1'b1;
    seen      = 1'b0;
    latency   = -1;
    stallLeft = stall;
    held      = '0;
    @(negedge clk);
    bus.s_ar_valid = 1'b1;
    bus.s_ar_addr  = addr;
    bus.s_ar_len   = len;
    bus.s_ar_id    = id;
    bus.s_r_ready  = (stall == 0);
    guard = 0;
    while (!bus.s_ar_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    hsCyc = cyc;
    @(posedge clk); #1;
    bus.s_ar_valid = 1'b0;
    guard = 0;
    while (!rxDone && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.s_r_valid) begin
        if (latency < 0) latency = cyc - hsCyc;
        if (!seen) begin
          held = bus.s_r_data;
          seen = 1'b1;
        end else if (rxCount == 0 && bus.s_r_data !== held) begin
          stableOk = 1'b0;
        end
        if (!bus.s_r_ready) begin
          stallLeft--;
          if (stallLeft <= 0) bus.s_r_ready = 1'b1;
        end
        if (bus.s_r_ready) begin
          if (rxCount == 0) rxId = bus.s_r_id;
          if (rxCount < 16) begin
            rxData[rxCount] = bus.s_r_data;
            rxResp[rxCount] = bus.s_r_resp;
            rxLast[rxCount] = bus.s_r_last;
          end
          rxCount++;
          if (bus.s_r_last) rxDone = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    bus.s_r_ready = 1'b1;
    arDelta = arCount - arBefore;
    checkOutput("readDone", 64'(rxDone), 64'd1);
  endtask

  logic [31:0] setAddr;

  initial begin
    bus.s_ar_valid = 1'b0;
    bus.s_ar_addr  = '0;
    bus.s_ar_len   = '0;
    bus.s_ar_id    = '0;
    bus.s_r_ready  = 1'b1;
    rxId = '0;

    repeat (2) @(negedge clk);
    checkOutput("rstArReady", 64'(bus.s_ar_ready), 64'd1);
    checkOutput("rstRValid",  64'(bus.s_r_valid),  64'd0);
    checkOutput("rstMArValid", 64'(bus.m_ar_valid), 64'd0);
    checkOutput("rstMRReady", 64'(bus.m_r_ready),  64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(32'h0000_1008, 8'd0, 6'd5, 0);
    checkOutput("coldArCount", 64'(arDelta), 64'd1);
    checkOutput("coldArAddr", 64'(lastArAddr), 64'h1000);
    checkOutput("coldArLen", 64'(lastArLen), 64'd1);
    checkOutput("coldData", rxData[0], memWord(32'h0000_1008));
    checkOutput("coldResp", 64'(rxResp[0]), 64'd0);
    checkOutput("coldLast", 64'(rxLast[0]), 64'd1);
    checkOutput("coldId", 64'(rxId), 64'd5);
    checkOutput("coldBeats", 64'(rxCount), 64'd1);

    applyStimulus(32'h0000_1000, 8'd0, 6'd3, 3);
    checkOutput("hitNoAr", 64'(arDelta), 64'd0);
    checkOutput("hitLatency", 64'(latency), 64'd2);
    checkOutput("hitData", rxData[0], memWord(32'h0000_1000));
    checkOutput("hitLast", 64'(rxLast[0]), 64'd1);
    checkOutput("hitId", 64'(rxId), 64'd3);
    checkOutput("hitStable", 64'(stableOk), 64'd1);

    for (int k = 0; k < 5; k++) begin
      setAddr = 32'h0010_0050 + 32'(k) * 32'h1000;
      applyStimulus(setAddr, 8'd0, 6'(k), 0);
      checkOutput("setFillMiss", 64'(arDelta), 64'd1);
      checkOutput("setFillData", rxData[0], memWord(setAddr));
    end
    applyStimulus(32'h0010_4050, 8'd0, 6'd1, 0);
    checkOutput("fifthTagHit", 64'(arDelta), 64'd0);
    applyStimulus(32'h0010_1050, 8'd0, 6'd1, 0);
    checkOutput("secondTagHit", 64'(arDelta), 64'd0);
    applyStimulus(32'h0010_0050, 8'd0, 6'd1, 0);
    checkOutput("evictedMiss", 64'(arDelta), 64'd1);

    applyStimulus(32'h0000_2000, 8'd3, 6'd9, 0);
    checkOutput("bypArAddr", 64'(lastArAddr), 64'h2000);
    checkOutput("bypArLen", 64'(lastArLen), 64'd3);
    checkOutput("bypBeats", 64'(rxCount), 64'd4);
    checkOutput("bypId", 64'(rxId), 64'd9);
    for (int i = 0; i < 4; i++) begin
      checkOutput("bypData", rxData[i], memWord(32'h0000_2000 + 32'(i * 8)));
      checkOutput("bypLast", 64'(rxLast[i]), 64'(i == 3));
    end
    applyStimulus(32'h0000_2000, 8'd0, 6'd2, 0);
    checkOutput("bypNoAlloc", 64'(arDelta), 64'd1);
    checkOutput("bypReLen", 64'(lastArLen), 64'd1);
    checkOutput("bypReData", rxData[0], memWord(32'h0000_2000));

    errBeat = 0;
    errCode = 2'b10;
    applyStimulus(32'h0000_3018, 8'd0, 6'd4, 0);
    errBeat = -1;
    checkOutput("errMiss", 64'(arDelta), 64'd1);
    checkOutput("errResp", 64'(rxResp[0]), 64'd2);
    applyStimulus(32'h0000_3018, 8'd0, 6'd4, 0);
    checkOutput("errReMiss", 64'(arDelta), 64'd1);
    checkOutput("errReResp", 64'(rxResp[0]), 64'd0);
    checkOutput("errReData", rxData[0], memWord(32'h0000_3018));

`ifdef RCACHE_INV_EN
    applyStimulus(32'h0000_1000, 8'd0, 6'd7, 0);
    checkOutput("invPreHit", 64'(arDelta), 64'd0);
    @(negedge clk);
    inv_valid = 1'b1;
    inv_addr  = 32'h0000_1000;
    @(negedge clk);
    inv_valid = 1'b0;
    applyStimulus(32'h0000_1000, 8'd0, 6'd7, 0);
    checkOutput("invMiss", 64'(arDelta), 64'd1);
    checkOutput("invData", rxData[0], memWord(32'h0000_1000));
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
